// File: rtl/pipeline_stall_ctrl.sv
// OF/EX/MA/RW pipeline registers driven by the data-interlock detector and branch resolution.
// Freezes PC/OF on interlock, bubbles EX, flushes wrong-path OF/EX on taken branches.
module pipeline_stall_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'h6800_0000,
  parameter int          CNT_W     = 16,
  parameter int          MAX_STALL = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      if_instruction,
  input  logic [31:0]      if_pc,
  input  logic             isDataInterLock,
  input  logic             isBranchTaken,
  output logic             pc_write_en,
  output logic [31:0]      of_ir,
  output logic [31:0]      ex_ir,
  output logic [31:0]      ma_ir,
  output logic [31:0]      rw_ir,
  output logic [31:0]      of_pc,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ma_pc,
  output logic [31:0]      rw_pc,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             stall_error
);

  localparam int RUN_W = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL + 1);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t           state_reg, state_next;
  logic [RUN_W-1:0] run_len_reg, run_len_next;
  logic             branch, stall;

  // The instruction in EX during FLUSH is a bubble, so a branch indication then is stale.
  assign branch = isBranchTaken && (state_reg != FLUSH);
  assign stall  = isDataInterLock && !branch;

  assign pc_write_en = !reset_n || !isDataInterLock || branch;

  always_comb begin
    state_next   = RUN;
    run_len_next = '0;
    if (branch) begin
      state_next = FLUSH;
    end else if (stall) begin
      state_next   = STALL;
      run_len_next = (run_len_reg == RUN_MAX) ? RUN_MAX : run_len_reg + RUN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      of_ir       <= NOP_INSTR;
      ex_ir       <= NOP_INSTR;
      ma_ir       <= NOP_INSTR;
      rw_ir       <= NOP_INSTR;
      of_pc       <= '0;
      ex_pc       <= '0;
      ma_pc       <= '0;
      rw_pc       <= '0;
      stall_count <= '0;
      flush_count <= '0;
      stall_error <= 1'b0;
      run_len_reg <= '0;
      state_reg   <= RUN;
    end else begin
      ma_ir       <= ex_ir;
      ma_pc       <= ex_pc;
      rw_ir       <= ma_ir;
      rw_pc       <= ma_pc;
      state_reg   <= state_next;
      run_len_reg <= run_len_next;
      if (branch) begin
        of_ir <= NOP_INSTR;
        of_pc <= '0;
        ex_ir <= NOP_INSTR;
        ex_pc <= '0;
        if (flush_count != '1) flush_count <= flush_count + CNT_W'(1);
      end else if (stall) begin
        ex_ir <= NOP_INSTR;
        ex_pc <= '0;
        if (stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      end else begin
        of_ir <= if_instruction;
        of_pc <= if_pc;
        ex_ir <= of_ir;
        ex_pc <= of_pc;
      end
      // Sticky until reset: the interlock has outlived the longest legal hazard.
      if (run_len_next == RUN_MAX) stall_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: default instance plus a CNT_W=2 instance
// sharing the same stimulus for counter-saturation checks.
module tb_pipeline_stall_ctrl;

  localparam logic [31:0] NOP = 32'h6800_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] if_instruction, if_pc;
  logic        isDataInterLock, isBranchTaken;

  logic        pc_write_en;
  logic [31:0] of_ir, ex_ir, ma_ir, rw_ir, of_pc, ex_pc, ma_pc, rw_pc;
  logic [15:0] stall_count, flush_count;
  logic        stall_error;

  logic        d2_pc_write_en;
  logic [31:0] d2_of_ir, d2_ex_ir, d2_ma_ir, d2_rw_ir, d2_of_pc, d2_ex_pc, d2_ma_pc, d2_rw_pc;
  logic [1:0]  d2_stall_count, d2_flush_count;
  logic        d2_stall_error;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl dut (
    .clk(clk), .reset_n(reset_n), .if_instruction(if_instruction), .if_pc(if_pc),
    .isDataInterLock(isDataInterLock), .isBranchTaken(isBranchTaken),
    .pc_write_en(pc_write_en),
    .of_ir(of_ir), .ex_ir(ex_ir), .ma_ir(ma_ir), .rw_ir(rw_ir),
    .of_pc(of_pc), .ex_pc(ex_pc), .ma_pc(ma_pc), .rw_pc(rw_pc),
    .stall_count(stall_count), .flush_count(flush_count), .stall_error(stall_error)
  );

  pipeline_stall_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .if_instruction(if_instruction), .if_pc(if_pc),
    .isDataInterLock(isDataInterLock), .isBranchTaken(isBranchTaken),
    .pc_write_en(d2_pc_write_en),
    .of_ir(d2_of_ir), .ex_ir(d2_ex_ir), .ma_ir(d2_ma_ir), .rw_ir(d2_rw_ir),
    .of_pc(d2_of_pc), .ex_pc(d2_ex_pc), .ma_pc(d2_ma_pc), .rw_pc(d2_rw_pc),
    .stall_count(d2_stall_count), .flush_count(d2_flush_count), .stall_error(d2_stall_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] check %-18s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic il, input logic br);
    if_instruction  = ins;
    if_pc           = pc;
    isDataInterLock = il;
    isBranchTaken   = br;
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_of_ir"}, of_ir, NOP);
    chk({tag, "_ex_ir"}, ex_ir, NOP);
    chk({tag, "_ma_ir"}, ma_ir, NOP);
    chk({tag, "_rw_ir"}, rw_ir, NOP);
    chk({tag, "_pcs"}, of_pc | ex_pc | ma_pc | rw_pc, 32'd0);
    chk({tag, "_stall_cnt"}, 32'(stall_count), 32'd0);
    chk({tag, "_flush_cnt"}, 32'(flush_count), 32'd0);
    chk({tag, "_stall_err"}, 32'(stall_error), 32'd0);
    chk({tag, "_d2_stall_cnt"}, 32'(d2_stall_count), 32'd0);
    chk({tag, "_d2_stall_err"}, 32'(d2_stall_error), 32'd0);
  endtask

  initial begin
    // 1: reset held two cycles
    reset_n = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    chk_reset_state("rst");
    chk("rst_pcwe", 32'(pc_write_en), 32'd1);

    // 2: free flow I0..I3, then I4
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(32'hA000_0000 + 32'(k), 32'(4 * k), 1'b0, 1'b0);
      chk("flow_pcwe", 32'(pc_write_en), 32'd1);
      step();
      if (k == 3) begin
        chk("flow_rw_ir", rw_ir, 32'hA000_0000);
        chk("flow_rw_pc", rw_pc, 32'd0);
        chk("flow_of_ir", of_ir, 32'hA000_0003);
      end
    end
    // OF=I4, EX=I3, MA=I2, RW=I1

    // 3: two-cycle interlock with I4 in OF
    drive(32'hA000_0005, 32'd20, 1'b1, 1'b0);
    chk("il1_pcwe", 32'(pc_write_en), 32'd0);
    step();
    chk("il1_of_ir", of_ir, 32'hA000_0004);
    chk("il1_ex_ir", ex_ir, NOP);
    chk("il1_ex_pc", ex_pc, 32'd0);
    chk("il1_ma_ir", ma_ir, 32'hA000_0003);
    chk("il2_pcwe", 32'(pc_write_en), 32'd0);
    step();
    chk("il2_of_ir", of_ir, 32'hA000_0004);
    chk("il2_of_pc", of_pc, 32'd16);
    chk("il2_ma_ir", ma_ir, NOP);
    chk("il2_rw_ir", rw_ir, 32'hA000_0003);
    chk("il2_stall_cnt", 32'(stall_count), 32'd2);
    drive(32'hA000_0005, 32'd20, 1'b0, 1'b0);
    chk("il_rel_pcwe", 32'(pc_write_en), 32'd1);
    step();
    chk("il3_of_ir", of_ir, 32'hA000_0005);
    chk("il3_ex_ir", ex_ir, 32'hA000_0004);
    chk("il3_ma_ir", ma_ir, NOP);
    chk("il3_rw_ir", rw_ir, NOP);
    chk("il3_stall_err", 32'(stall_error), 32'd0);

    // 4: branch with interlock also asserted
    drive(32'hA000_0006, 32'd24, 1'b1, 1'b1);
    chk("br_pcwe", 32'(pc_write_en), 32'd1);
    step();
    chk("br_of_ir", of_ir, NOP);
    chk("br_ex_ir", ex_ir, NOP);
    chk("br_of_pc", of_pc, 32'd0);
    chk("br_ma_ir", ma_ir, 32'hA000_0004);
    chk("br_ma_pc", ma_pc, 32'd16);
    chk("br_flush_cnt", 32'(flush_count), 32'd1);
    chk("br_stall_cnt", 32'(stall_count), 32'd2);
    drive(32'hB000_0000, 32'h200, 1'b0, 1'b1);
    step();
    chk("br2_flush_cnt", 32'(flush_count), 32'd1);
    chk("br2_of_ir", of_ir, 32'hB000_0000);
    chk("br2_of_pc", of_pc, 32'h200);
    chk("br2_rw_ir", rw_ir, 32'hA000_0004);

    // 5: four-cycle interlock trips the watchdog
    drive(32'hB000_0001, 32'h204, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 2) chk("wd3_stall_err", 32'(stall_error), 32'd0);
    end
    chk("wd4_stall_err", 32'(stall_error), 32'd1);
    chk("wd4_stall_cnt", 32'(stall_count), 32'd6);
    chk("wd4_of_ir", of_ir, 32'hB000_0000);
    drive(32'hB000_0001, 32'h204, 1'b0, 1'b0);
    step();
    chk("wd_sticky", 32'(stall_error), 32'd1);

    // 6: fresh reset, CNT_W=2 saturation, reset mid-stall
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    drive(32'hC000_0000, 32'h300, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step();
    chk("sat_d2_stall_cnt", 32'(d2_stall_count), 32'd3);
    chk("sat_stall_cnt", 32'(stall_count), 32'd5);
    chk("sat_d2_stall_err", 32'(d2_stall_error), 32'd1);
    reset_n = 1'b0;
    drive(32'hC000_0000, 32'h300, 1'b1, 1'b1);
    chk("rst_il_pcwe", 32'(pc_write_en), 32'd1);
    chk("rst_il_d2_pcwe", 32'(d2_pc_write_en), 32'd1);
    step();
    chk_reset_state("rst2");
    reset_n = 1'b1;
    drive(32'hC000_0000, 32'h300, 1'b0, 1'b0);
    chk("post_rst_pcwe", 32'(pc_write_en), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
